// File: rtl/adam_kbd_pkg.sv
// Scancode and ADAM keycode constants plus the PS/2 set-2 to ADAM translation.
// Shared by the keyboard front end and its FIFO.
package adam_kbd_pkg;

   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_BKSP   = 8'h66;
   localparam logic [7:0] SC_ESC    = 8'h76;
   localparam logic [7:0] SC_TAB    = 8'h0D;
   localparam logic [7:0] SC_SPACE  = 8'h29;
   localparam logic [7:0] SC_UP     = 8'h75;
   localparam logic [7:0] SC_RIGHT  = 8'h74;
   localparam logic [7:0] SC_DOWN   = 8'h72;
   localparam logic [7:0] SC_LEFT   = 8'h6B;
   localparam logic [7:0] SC_F1     = 8'h05;
   localparam logic [7:0] SC_F2     = 8'h06;
   localparam logic [7:0] SC_F3     = 8'h04;
   localparam logic [7:0] SC_F4     = 8'h0C;
   localparam logic [7:0] SC_F5     = 8'h03;
   localparam logic [7:0] SC_F6     = 8'h0B;

   localparam logic [7:0] ADAM_CR     = 8'h0D;
   localparam logic [7:0] ADAM_BS     = 8'h08;
   localparam logic [7:0] ADAM_ESC    = 8'h1B;
   localparam logic [7:0] ADAM_TAB    = 8'h09;
   localparam logic [7:0] ADAM_SPACE  = 8'h20;
   localparam logic [7:0] ADAM_UP     = 8'hA0;
   localparam logic [7:0] ADAM_RIGHT  = 8'hA1;
   localparam logic [7:0] ADAM_DOWN   = 8'hA2;
   localparam logic [7:0] ADAM_LEFT   = 8'hA3;
   localparam logic [7:0] ADAM_SMART1 = 8'h81;
   localparam logic [7:0] ADAM_SMART_SHIFT = 8'h08;
   localparam logic [7:0] ADAM_LOWER_A = 8'h61;
   localparam logic [7:0] ADAM_UPPER_A = 8'h41;

   typedef struct packed {
      logic hit;
      logic [7:0] code;
   } xlate_t;

   typedef struct packed {
      logic caps;
      logic ctrl;
      logic shift;
   } mods_t;

   // {valid, alphabet index}
   function automatic logic [5:0] letter_ord(input logic [7:0] sc);
      logic [5:0] r;
      case (sc)
         8'h1C: r = 6'd32; 8'h32: r = 6'd33;
         8'h21: r = 6'd34; 8'h23: r = 6'd35;
         8'h24: r = 6'd36; 8'h2B: r = 6'd37;
         8'h34: r = 6'd38; 8'h33: r = 6'd39;
         8'h43: r = 6'd40; 8'h3B: r = 6'd41;
         8'h42: r = 6'd42; 8'h4B: r = 6'd43;
         8'h3A: r = 6'd44; 8'h31: r = 6'd45;
         8'h44: r = 6'd46; 8'h4D: r = 6'd47;
         8'h15: r = 6'd48; 8'h2D: r = 6'd49;
         8'h1B: r = 6'd50; 8'h2C: r = 6'd51;
         8'h3C: r = 6'd52; 8'h2A: r = 6'd53;
         8'h1D: r = 6'd54; 8'h22: r = 6'd55;
         8'h35: r = 6'd56; 8'h1A: r = 6'd57;
         default: r = 6'd0;
      endcase
      return r;
   endfunction

   // {shifted, plain}; zero means unmapped
   function automatic logic [15:0] sym_pair(input logic [7:0] sc);
      logic [15:0] p;
      case (sc)
         8'h16: p = 16'h2131; 8'h1E: p = 16'h4032;
         8'h26: p = 16'h2333; 8'h25: p = 16'h2434;
         8'h2E: p = 16'h2535; 8'h36: p = 16'h5E36;
         8'h3D: p = 16'h2637; 8'h3E: p = 16'h2A38;
         8'h46: p = 16'h2839; 8'h45: p = 16'h2930;
         8'h0E: p = 16'h7E60; 8'h4E: p = 16'h5F2D;
         8'h55: p = 16'h2B3D; 8'h54: p = 16'h7B5B;
         8'h5B: p = 16'h7D5D; 8'h5D: p = 16'h7C5C;
         8'h4C: p = 16'h3A3B; 8'h52: p = 16'h2227;
         8'h41: p = 16'h3C2C; 8'h49: p = 16'h3E2E;
         8'h4A: p = 16'h3F2F;
         SC_ENTER: p = {ADAM_CR, ADAM_CR};
         SC_BKSP:  p = {ADAM_BS, ADAM_BS};
         SC_ESC:   p = {ADAM_ESC, ADAM_ESC};
         SC_TAB:   p = {ADAM_TAB, ADAM_TAB};
         SC_SPACE: p = {ADAM_SPACE, ADAM_SPACE};
         default:  p = 16'h0000;
      endcase
      return p;
   endfunction

   // {valid, smart key number}
   function automatic logic [3:0] fkey_ord(input logic [7:0] sc);
      logic [3:0] r;
      case (sc)
         SC_F1: r = 4'h8; SC_F2: r = 4'h9;
         SC_F3: r = 4'hA; SC_F4: r = 4'hB;
         SC_F5: r = 4'hC; SC_F6: r = 4'hD;
         default: r = 4'h0;
      endcase
      return r;
   endfunction

   function automatic xlate_t adam_translate(
      input logic [7:0] sc,
      input logic       ext,
      input mods_t      m
   );
      xlate_t x;
      logic [5:0] l;
      logic [15:0] p;
      logic [3:0] f;
      logic [7:0] idx;
      x = '0;
      l = letter_ord(sc);
      p = sym_pair(sc);
      f = fkey_ord(sc);
      idx = {3'b000, l[4:0]};
      if (ext) begin
         x.hit = 1'b1;
         case (sc)
            SC_UP:    x.code = ADAM_UP;
            SC_RIGHT: x.code = ADAM_RIGHT;
            SC_DOWN:  x.code = ADAM_DOWN;
            SC_LEFT:  x.code = ADAM_LEFT;
            default:  x = '0;
         endcase
      end else if (l[5]) begin
         x.hit = 1'b1;
         // ctrl wins over case selection
         if (m.ctrl)
            x.code = (ADAM_UPPER_A + idx) & 8'h1F;
         else if (m.shift ^ m.caps)
            x.code = ADAM_UPPER_A + idx;
         else
            x.code = ADAM_LOWER_A + idx;
      end else if (f[3]) begin
         x.hit = 1'b1;
         x.code = ADAM_SMART1 + {5'b00000, f[2:0]};
         if (m.shift)
            x.code = x.code + ADAM_SMART_SHIFT;
      end else if (p != 16'h0000) begin
         x.hit = 1'b1;
         x.code = m.shift ? p[15:8] : p[7:0];
      end
      return x;
   endfunction

endpackage

// File: rtl/adam_kbd_fifo.sv
// Synchronous keycode FIFO; a push into a full FIFO lands only
// when a pop happens on the same edge.
module adam_kbd_fifo
   import adam_kbd_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_count;
   logic             w_pop;
   logic             w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CNT_FULL);
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_dout  = o_empty ? '0 : r_mem[r_rd];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wr <= r_wr + PTR_ONE;
         if (w_pop)
            r_rd <= r_rd + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr] <= i_din;
   end

endmodule

// File: rtl/adam_ps2_keyboard.sv
// PS/2 key event to ADAM keycode front end: edge detect, modifier
// tracking, two-stage translation pipeline feeding a keycode FIFO.
module adam_ps2_keyboard
   import adam_kbd_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   output logic        key_valid,
   output logic [7:0]  key_data,
   input  logic        key_ready,
   output logic        overflow,
   input  logic        overflow_clr,
   output logic [2:0]  mod_state
);

   logic       r_tog;
   logic       w_event;
   logic [7:0] w_sc;
   logic       w_ext;
   logic       w_pressed;

   logic       r_lshift;
   logic       r_rshift;
   logic       r_lctrl;
   logic       r_rctrl;
   logic       r_caps;
   mods_t      w_mods;

   logic       r_s1_valid;
   logic [7:0] r_s1_sc;
   logic       r_s1_ext;
   mods_t      r_s1_mods;
   xlate_t     w_xlate;

   logic       r_s2_valid;
   logic [7:0] r_s2_code;

   logic       w_empty;
   logic       w_full;
   logic       w_pop;
   logic       w_drop;
   logic       r_overflow;

   assign w_sc      = ps2_key[7:0];
   assign w_ext     = ps2_key[8];
   assign w_pressed = ps2_key[9];
   assign w_event   = ps2_key[10] ^ r_tog;

   // Follows the input even during reset, so release never sees an edge.
   always_ff @(posedge clk_sys) begin
      r_tog <= ps2_key[10];
   end

   assign w_mods.caps  = r_caps;
   assign w_mods.ctrl  = r_lctrl | r_rctrl;
   assign w_mods.shift = r_lshift | r_rshift;
   assign mod_state    = w_mods;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_lshift <= 1'b0;
         r_rshift <= 1'b0;
         r_lctrl  <= 1'b0;
         r_rctrl  <= 1'b0;
         r_caps   <= 1'b0;
      end else if (w_event) begin
         if (w_sc == SC_LSHIFT)
            r_lshift <= w_pressed;
         if (w_sc == SC_RSHIFT)
            r_rshift <= w_pressed;
         if (w_sc == SC_CTRL && !w_ext)
            r_lctrl <= w_pressed;
         if (w_sc == SC_CTRL && w_ext)
            r_rctrl <= w_pressed;
         if (w_sc == SC_CAPS && !w_ext && w_pressed)
            r_caps <= ~r_caps;
      end
   end

   // Stage 1 snapshots the pre-event modifiers with the event.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_sc    <= '0;
         r_s1_ext   <= 1'b0;
         r_s1_mods  <= '0;
      end else begin
         r_s1_valid <= w_event & w_pressed;
         r_s1_sc    <= w_sc;
         r_s1_ext   <= w_ext;
         r_s1_mods  <= w_mods;
      end
   end

   always_comb begin
      w_xlate = adam_translate(r_s1_sc, r_s1_ext, r_s1_mods);
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_s2_valid <= 1'b0;
         r_s2_code  <= '0;
      end else begin
         r_s2_valid <= r_s1_valid & w_xlate.hit;
         r_s2_code  <= w_xlate.code;
      end
   end

   assign key_valid = ~w_empty;
   assign w_pop     = key_valid & key_ready;
   assign w_drop    = r_s2_valid & w_full & ~w_pop;

   adam_kbd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk_sys),
      .rst     (reset),
      .i_push  (r_s2_valid),
      .i_din   (r_s2_code),
      .i_pop   (key_ready),
      .o_dout  (key_data),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)
         r_overflow <= 1'b0;
      else if (w_drop)
         r_overflow <= 1'b1;
      else if (overflow_clr)
         r_overflow <= 1'b0;
   end

   assign overflow = r_overflow;

endmodule

// File: tb/tb_adam_ps2_keyboard.sv
// Scoreboard bench for adam_ps2_keyboard.
// Model-driven expected queue, negedge monitor.
module tb_adam_ps2_keyboard;

  localparam int DEPTH = 8;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = 11'h400;
  logic        key_ready = 1'b0;
  logic        overflow_clr = 1'b0;
  logic        key_valid;
  logic [7:0]  key_data;
  logic        overflow;
  logic [2:0]  mod_state;

  adam_ps2_keyboard #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_key      (ps2_key),
    .key_valid    (key_valid),
    .key_data     (key_data),
    .key_ready    (key_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .mod_state    (mod_state)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;
  byte unsigned exp_q[$];
  bit exp_ovf = 0;
  bit m_lsh, m_rsh, m_lct, m_rct, m_caps;

  byte unsigned letter_map[byte unsigned];
  byte unsigned low_map[byte unsigned];
  byte unsigned sh_map[byte unsigned];
  byte unsigned fkeys[6] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B};
  byte unsigned letter_sc[26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned sym_sc[21] = '{
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
    8'h41, 8'h49, 8'h4A};
  string s_letters = "abcdefghijklmnopqrstuvwxyz";
  string s_low = "1234567890`-=[]|;',./";
  string s_sh  = "!@#$%^&*()~_+{}|:'<>?";
  byte unsigned pool[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic bit model(input byte unsigned sc, input bit ext,
                               output byte unsigned v);
    bit sh = m_lsh | m_rsh;
    bit ct = m_lct | m_rct;
    v = 8'h00;
    if (ext) begin
      case (sc)
        8'h75: v = 8'hA0;
        8'h74: v = 8'hA1;
        8'h72: v = 8'hA2;
        8'h6B: v = 8'hA3;
        default: return 0;
      endcase
      return 1;
    end
    if (letter_map.exists(sc)) begin
      v = letter_map[sc];
      if (ct) v = v & 8'h1F;
      else if (sh ^ m_caps) v = v - 8'h20;
      return 1;
    end
    if (low_map.exists(sc)) begin
      v = sh ? sh_map[sc] : low_map[sc];
      return 1;
    end
    for (int i = 0; i < 6; i++)
      if (fkeys[i] == sc) begin
        v = 8'h81 + 8'(i) + (sh ? 8'h08 : 8'h00);
        return 1;
      end
    return 0;
  endfunction

  function automatic logic [2:0] exp_mods();
    return {m_caps, m_lct | m_rct, m_lsh | m_rsh};
  endfunction

  task automatic send(input byte unsigned sc, input bit ext, input bit pr,
                      input bit pop_at_write);
    byte unsigned v;
    bit hit;
    ps2_key = {~ps2_key[10], pr, ext, sc};
    hit = model(sc, ext, v);
    if (pr && hit) begin
      if (exp_q.size() >= DEPTH && !pop_at_write) exp_ovf = 1;
      else exp_q.push_back(v);
    end
    if (sc == 8'h12) m_lsh = pr;
    if (sc == 8'h59) m_rsh = pr;
    if (sc == 8'h14) begin
      if (ext) m_rct = pr;
      else m_lct = pr;
    end
    if (sc == 8'h58 && !ext && pr) m_caps = !m_caps;
    tick();
  endtask

  task automatic drain();
    int t = 0;
    key_ready = 1;
    repeat (3) tick();
    while ((exp_q.size() != 0 || key_valid) && t < 200) begin
      tick();
      t++;
    end
    n_checks++;
    if (t >= 200) begin
      n_errors++;
      $display("FAIL drain: got %0d codes pending, expected 0",
               exp_q.size());
    end
    key_ready = 0;
  endtask

  always @(negedge clk_sys) begin
    if (!reset && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_code: got 0x%02h, expected none",
                 key_data);
      end else begin
        check("key_data", {24'h0, key_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 26; i++) begin
      letter_map[letter_sc[i]] = s_letters[i];
      pool.push_back(letter_sc[i]);
    end
    for (int i = 0; i < 21; i++) begin
      low_map[sym_sc[i]] = s_low[i];
      sh_map[sym_sc[i]] = s_sh[i];
      pool.push_back(sym_sc[i]);
    end
    low_map[8'h5D] = 8'h5C;
    sh_map[8'h52] = 8'h22;
    low_map[8'h5A] = 8'h0D; sh_map[8'h5A] = 8'h0D;
    low_map[8'h66] = 8'h08; sh_map[8'h66] = 8'h08;
    low_map[8'h76] = 8'h1B; sh_map[8'h76] = 8'h1B;
    low_map[8'h0D] = 8'h09; sh_map[8'h0D] = 8'h09;
    low_map[8'h29] = 8'h20; sh_map[8'h29] = 8'h20;
    pool = {pool, 8'h5A, 8'h66, 8'h76, 8'h0D, 8'h29, 8'h05, 8'h06,
            8'h04, 8'h0C, 8'h03, 8'h0B, 8'h75, 8'h74, 8'h72, 8'h6B,
            8'h12, 8'h59, 8'h14, 8'h58, 8'h12, 8'h14, 8'h58, 8'h7E,
            8'h77, 8'h00};

    repeat (3) tick();
    reset = 0;
    repeat (3) tick();
    check("rst_valid", {31'h0, key_valid}, 0);
    check("rst_data", {24'h0, key_data}, 0);
    check("rst_ovf", {31'h0, overflow}, 0);
    check("rst_mods", {29'h0, mod_state}, 0);
    check("rst_count", 32'(dut.u_fifo.r_count), 0);

    send(8'h1C, 0, 1, 0);
    check("lat_n", {31'h0, key_valid}, 0);
    tick();
    check("lat_n1", {31'h0, key_valid}, 0);
    tick();
    check("lat_n2", {31'h0, key_valid}, 1);
    check("lat_data", {24'h0, key_data}, 32'h61);
    send(8'h1C, 0, 0, 0);
    drain();

    send(8'h12, 0, 1, 0);
    send(8'h1C, 0, 1, 0);
    send(8'h58, 0, 1, 0);
    send(8'h1C, 0, 1, 0);
    check("mods_101", {29'h0, mod_state}, {29'h0, exp_mods()});
    check("mods_101c", {29'h0, mod_state}, 5);
    drain();
    send(8'h12, 0, 0, 0);
    send(8'h58, 0, 1, 0);
    send(8'h58, 0, 0, 0);
    check("mods_clr", {29'h0, mod_state}, 0);

    send(8'h75, 1, 1, 0);
    send(8'h59, 0, 1, 0);
    send(8'h05, 0, 1, 0);
    send(8'h59, 0, 0, 0);
    drain();

    send(8'h14, 1, 1, 0);
    send(8'h1C, 0, 1, 0);
    send(8'h14, 1, 0, 0);
    drain();

    key_ready = 0;
    for (int i = 0; i < 9; i++)
      send(letter_sc[$urandom_range(0, 25)], 0, 1, 0);
    repeat (3) tick();
    check("ovf_set", {31'h0, overflow}, {31'h0, exp_ovf});
    check("ovf_count", 32'(dut.u_fifo.r_count), DEPTH);
    overflow_clr = 1;
    tick();
    overflow_clr = 0;
    exp_ovf = 0;
    check("ovf_clr", {31'h0, overflow}, 0);
    drain();

    for (int i = 0; i < DEPTH; i++)
      send(sym_sc[$urandom_range(0, 20)], 0, 1, 0);
    repeat (3) tick();
    check("full_count", 32'(dut.u_fifo.r_count), DEPTH);
    send(letter_sc[$urandom_range(0, 25)], 0, 1, 1);
    tick();
    key_ready = 1;
    tick();
    key_ready = 0;
    tick();
    check("pp_count", 32'(dut.u_fifo.r_count), DEPTH);
    check("pp_ovf", {31'h0, overflow}, 0);
    drain();

    for (int i = 0; i < 300; i++) begin
      int g = 0;
      byte unsigned sc;
      bit ext, pr;
      while (exp_q.size() >= DEPTH && g < 100) begin
        key_ready = 1;
        tick();
        g++;
      end
      if (g >= 100) begin
        n_checks++;
        n_errors++;
        $display("FAIL rand_stall: got %0d queued, expected < %0d",
                 exp_q.size(), DEPTH);
      end
      sc = pool[$urandom_range(0, pool.size() - 1)];
      ext = 0;
      if (sc == 8'h75 || sc == 8'h74 || sc == 8'h72 ||
          sc == 8'h6B || sc == 8'h14)
        ext = 1'($urandom_range(0, 1));
      pr = ($urandom_range(0, 9) < 7);
      key_ready = ($urandom_range(0, 3) != 0);
      send(sc, ext, pr, 0);
      check("rand_mods", {29'h0, mod_state}, {29'h0, exp_mods()});
      repeat ($urandom_range(0, 2)) begin
        key_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    send(8'h12, 0, 0, 0);
    send(8'h59, 0, 0, 0);
    send(8'h14, 0, 0, 0);
    send(8'h14, 1, 0, 0);
    if (m_caps) send(8'h58, 0, 1, 0);
    check("rand_mods_end", {29'h0, mod_state}, 0);
    check("rand_ovf", {31'h0, overflow}, {31'h0, exp_ovf});
    drain();

    send(8'h12, 0, 1, 0);
    send(8'h1C, 0, 1, 0);
    reset = 1;
    exp_q.delete();
    m_lsh = 0; m_rsh = 0; m_lct = 0; m_rct = 0; m_caps = 0;
    key_ready = 1;
    repeat (2) tick();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_flight_valid", {31'h0, key_valid}, 0);
    end
    check("rst_flight_mods", {29'h0, mod_state}, 0);
    key_ready = 0;
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adam_ps2_keyboard.md
ADAM_PS2_KEYBOARD -- requirements
Module: adam_ps2_keyboard

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the translated-keycode FIFO depth; power of two, minimum 2.
REQ-002 SHALL have port clk_sys, input, 1 bit: the single system clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port ps2_key, input, 11 bits: [7:0] scancode, [8] extended, [9] pressed, [10] toggles on every event.
REQ-005 SHALL have port key_valid, output, 1 bit: FIFO head holds a code.
REQ-006 SHALL have port key_data, output, 8 bits: ADAM keycode at FIFO head.
REQ-007 SHALL have port key_ready, input, 1 bit: consumer (console ADAMnet keyboard device) accepts the head.
REQ-008 SHALL have port overflow, output, 1 bit: sticky, set when a code was dropped.
REQ-009 SHALL have port overflow_clr, input, 1 bit: clears overflow.
REQ-010 SHALL have port mod_state, output, 3 bits: {caps_lock, ctrl, shift}.

Function
REQ-011 SHALL register ps2_key[10] and flag an event on any cycle where it differs from the registered copy; no event fires in the first cycle after reset.
REQ-012 SHALL treat scancodes 0x12/0x59 as shift and 0x14 (plain or extended) as ctrl; level follows pressed bit; left/right shift are tracked independently and ORed.
REQ-013 SHALL toggle caps_lock on press of 0x58; release has no effect.
REQ-014 SHALL translate on press events only; releases never push.
REQ-015 Letters: SHALL output lowercase ASCII (0x1C -> 0x61), uppercase when shift XOR caps_lock (0x41); ctrl forces code & 0x1F (ctrl+A -> 0x01), overriding case.
REQ-016 Digits/punctuation: SHALL output US-layout ASCII; shift selects the shifted symbol; caps_lock ignored.
REQ-017 Specials: SHALL map 0x5A -> 0x0D, 0x66 -> 0x08, 0x76 -> 0x1B, 0x0D -> 0x09, 0x29 -> 0x20.
REQ-018 Extended arrows: SHALL map up 0x75 -> 0xA0, right 0x74 -> 0xA1, down 0x72 -> 0xA2, left 0x6B -> 0xA3.
REQ-019 F1..F6 (0x05,0x06,0x04,0x0C,0x03,0x0B) SHALL map to smart keys 0x81..0x86; shift adds 0x08 (0x89..0x8E).
REQ-020 Unmapped presses (including modifier keys themselves) SHALL produce no push.
REQ-021 Pipeline: event sampled at edge N, translation registered at edge N+1, FIFO written at edge N+2; key_valid high after edge N+2 when FIFO was empty.
REQ-022 key_valid SHALL equal FIFO not-empty; key_data SHALL be the head, stable while key_valid & ~key_ready.
REQ-023 A pop SHALL occur at an edge with key_valid & key_ready; key_ready while empty is ignored.
REQ-024 A push to a full FIFO SHALL be accepted if a pop occurs at the same edge; otherwise the code is dropped and overflow is set.
REQ-025 overflow_clr SHALL clear overflow; a simultaneous drop SHALL win (overflow stays 1).
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-027 Modifier state changes SHALL take effect for the next event only, not the one in flight.

Reset
REQ-028 reset SHALL asynchronously clear FIFO pointers/count, key_valid=0, key_data=0x00, overflow=0, mod_state=3'b000, pipeline valid flags, and load the toggle register from ps2_key[10] on release of reset.
REQ-029 Reset mid-pipeline SHALL discard in-flight translations; no code appears after reset deasserts until a new event.

Structure
REQ-030 Scancode constants, ADAM keycode constants (ADAM_UP, ADAM_SMART1, ...) and the translation function SHALL live in package adam_kbd_pkg.
REQ-031 The FIFO SHALL be a sub-module adam_kbd_fifo (sync, full/empty, simultaneous push/pop); translation stays in the top.

Verification
REQ-032 Press 0x1C (toggle flip) -> key_valid at cycle 2, key_data 0x61; release 0x1C -> no push.
REQ-033 Press 0x12, press 0x1C, press 0x58, press 0x1C -> codes 0x41 then 0x61; mod_state 3'b101.
REQ-034 Press extended 0x75, then 0x05 with shift held -> 0xA0 then 0x89.
REQ-035 key_ready=0, 9 letter presses with FIFO_DEPTH 8 -> 8 codes retained in order, overflow=1; overflow_clr -> 0.
REQ-036 FIFO full, push coincident with pop -> no drop, count stays 8, overflow stays 0.
REQ-037 Assert reset one cycle after an event -> key_valid stays 0 afterwards, mod_state 3'b000.
